// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: sequences one external one-digit BCD adder
// across NDIGITS digits. Define BCD_DIGIT_CHECK_EN to add the err port and operand digit checking.
module bcd_serial_add_ctrl #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] augend,
  input  logic [4*NDIGITS-1:0] addend,
  input  logic                 cin,
  output logic [3:0]           dig_a,
  output logic [3:0]           dig_b,
  output logic                 dig_cin,
  input  logic [3:0]           dig_sum,
  input  logic                 dig_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIGITS-1:0] sum,
  output logic                 cout
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  aug_q;
  logic [W-1:0]  add_q;
  logic          carry_q;

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic bad_operand;
  assign bad_operand = has_bad_digit(augend) | has_bad_digit(addend);
`endif

  // Operands are captured at acceptance so callers may change them mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      aug_q   <= '0;
      add_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            aug_q   <= augend;
            add_q   <= addend;
            carry_q <= cin;
            idx_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err     <= bad_operand;
            state_q <= bad_operand ? DONE : RUN;
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          sum[{idx_q, 2'b00} +: 4] <= dig_sum;
          carry_q <= dig_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cout    <= dig_cout;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The external adder only sees live digits while running; otherwise zeros.
  always_comb begin
    dig_a   = 4'd0;
    dig_b   = 4'd0;
    dig_cin = 1'b0;
    if (state_q == RUN) begin
      dig_a   = aug_q[{idx_q, 2'b00} +: 4];
      dig_b   = add_q[{idx_q, 2'b00} +: 4];
      dig_cin = carry_q;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl with a behavioural one-digit BCD
// adder attached and a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int NDIGITS = 4;
  localparam int W = 4 * NDIGITS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] augend;
  logic [W-1:0] addend;
  logic         cin;
  logic [3:0]   dig_a;
  logic [3:0]   dig_b;
  logic         dig_cin;
  logic [3:0]   dig_sum;
  logic         dig_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BCD_DIGIT_CHECK_EN
  logic         err;
`endif

  int errors = 0;
  int checks = 0;

  bcd_serial_add_ctrl #(.NDIGITS(NDIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .augend(augend),
    .addend(addend),
    .cin(cin),
    .dig_a(dig_a),
    .dig_b(dig_b),
    .dig_cin(dig_cin),
    .dig_sum(dig_sum),
    .dig_cout(dig_cout),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External one-digit BCD adder: decimal sum of two digits plus carry.
  logic [4:0] digit_total;
  assign digit_total = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, dig_cin};
  assign dig_cout    = (digit_total > 5'd9);
  assign dig_sum     = dig_cout ? 4'(digit_total - 5'd10) : digit_total[3:0];

  function automatic longint bcdValue(input logic [W-1:0] v);
    longint r;
    r = 0;
    for (int i = NDIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] toBcd(input longint x);
    logic [W-1:0] r;
    longint t;
    r = '0;
    t = x;
    for (int i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint decLimit();
    longint p;
    p = 1;
    for (int i = 0; i < NDIGITS; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [W-1:0] randomBcd();
    logic [W-1:0] r;
    for (int i = 0; i < NDIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches one addition and checks timing, digit presentation and result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input string tag);
    longint total;
    logic [W-1:0] exp_sum;
    logic exp_cout;
    int n;
    total    = bcdValue(a) + bcdValue(b) + longint'(c);
    exp_sum  = toBcd(total % decLimit());
    exp_cout = (total >= decLimit());

    @(negedge clk);
    augend = a;
    addend = b;
    cin    = c;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    augend = W'($urandom);
    addend = W'($urandom);
    cin    = 1'($urandom);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    checkOutput({tag, "_dig_a0"}, 64'(dig_a), 64'(a[3:0]));
    checkOutput({tag, "_dig_cin0"}, 64'(dig_cin), 64'(c));
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(NDIGITS));
    checkOutput({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    checkOutput({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, 64'(done), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hold_sum"}, 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    int n;
    int pulses;

    rst    = 1'b1;
    start  = 1'b0;
    augend = '0;
    addend = '0;
    cin    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sum", 64'(sum), 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_dig_a", 64'(dig_a), 64'd0);
    checkOutput("idle_dig_cin", 64'(dig_cin), 64'd0);

    applyStimulus(16'h1234, 16'h5678, 1'b0, "basic");
    applyStimulus(16'h9999, 16'h0001, 1'b0, "ripple");
    applyStimulus(16'h9999, 16'h9999, 1'b1, "max");
    applyStimulus(16'h0000, 16'h0000, 1'b1, "cin_only");

    // A second start two cycles into a run must be ignored entirely.
    @(negedge clk);
    augend = 16'h0500;
    addend = 16'h0500;
    cin    = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    augend = 16'h0001;
    addend = 16'h0001;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_start_latency", 64'(n), 64'(NDIGITS));
    checkOutput("busy_start_sum", 64'(sum), 64'h1000);
    checkOutput("busy_start_cout", 64'(cout), 64'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("busy_start_extra_done", 64'(pulses), 64'd0);

    // Reset after two digit captures aborts the run with no done pulse.
    @(negedge clk);
    augend = 16'h4444;
    addend = 16'h3333;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_sum", 64'(sum), 64'd0);
    checkOutput("abort_cout", 64'(cout), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_dig_a", 64'(dig_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_no_done", 64'(pulses), 64'd0);
    applyStimulus(16'h0003, 16'h0005, 1'b0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(randomBcd(), randomBcd(), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
